// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for register-file writer paths: index width, data width and
// the writeback request bundle.
package rf_wb_arbiter_pkg;
    localparam int REG_W = 5;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        logic            valid;
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/rf_pending_sb.sv
// Per-register pending-write counters: issue increments, register-file write
// decrements, busy and issue_ready derived from the counts.
module rf_pending_sb
    import rf_wb_arbiter_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  reg_idx_t        issue_rd,
    output logic            issue_ready,
    input  logic            dec_valid,
    input  reg_idx_t        dec_rd,
    output logic [NREG-1:0] busy
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt [NREG];
    logic             inc_valid;

    // A write retiring the same register this cycle frees a slot for issue.
    assign issue_ready = (cnt[issue_rd] != CNT_MAX) || (dec_valid && (dec_rd == issue_rd));
    assign inc_valid   = issue_valid && issue_ready && (issue_rd != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (inc_valid && (issue_rd == reg_idx_t'(r)) &&
                    !(dec_valid && (dec_rd == reg_idx_t'(r)))) begin
                    if (cnt[r] != CNT_MAX) begin
                        cnt[r] <= cnt[r] + CNT_W'(1);
                    end
                end else if (dec_valid && (dec_rd == reg_idx_t'(r)) &&
                             !(inc_valid && (issue_rd == reg_idx_t'(r)))) begin
                    // Decrement of an idle register is a protocol error; hold at zero.
                    if (cnt[r] != '0) begin
                        cnt[r] <= cnt[r] - CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < NREG; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-producer writeback arbiter for the register file write port, with
// starvation protection for the mul/div source and a pending-write scoreboard.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int CNT_W        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  reg_idx_t        issue_rd,
    output logic            issue_ready,
    input  logic            s0_valid,
    output logic            s0_ready,
    input  reg_idx_t        s0_rd,
    input  logic [XLEN-1:0] s0_data,
    input  logic            s1_valid,
    output logic            s1_ready,
    input  reg_idx_t        s1_rd,
    input  logic [XLEN-1:0] s1_data,
    output logic            rf_we,
    output reg_idx_t        rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] busy
);
    localparam int ST_W = $clog2(STARVE_LIMIT + 1);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Ready is a function of arbiter state only, plus s0_valid for s1_ready.
    logic [ST_W-1:0] starve_cnt;
    logic            force_grant;
    wb_req_t         win;

    assign force_grant = (starve_cnt == ST_W'(STARVE_LIMIT));
    assign s0_ready    = !force_grant;
    assign s1_ready    = force_grant || !s0_valid;

    always_comb begin
        win = '0;
        if (s0_valid && s0_ready) begin
            win = '{valid: 1'b1, rd: s0_rd, data: s0_data};
        end else if (s1_valid && s1_ready) begin
            win = '{valid: 1'b1, rd: s1_rd, data: s1_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (s1_valid && !s1_ready) begin
            if (!force_grant) begin
                starve_cnt <= starve_cnt + ST_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // Results for x0 are accepted but never reach the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= win.valid && (win.rd != '0);
            if (win.valid && (win.rd != '0)) begin
                rf_waddr <= win.rd;
                rf_wdata <= win.data;
            end
        end
    end

    rf_pending_sb #(
        .CNT_W(CNT_W)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .dec_valid  (rf_we),
        .dec_rd     (rf_waddr),
        .busy       (busy)
    );
endmodule
